// File: rtl/rename_stall_ctrl.sv
// -----------------------------------------------------------------------------
// rename_stall_ctrl
//
// Issue-path scheduler in front of a 1-bit register renamer. It tracks how
// many writers to each architectural destination are still in flight, with
// separate GPR and FPR tables. When a new writer would need a rename name
// that is still in use, the issue handshake is withheld until a commit frees
// one.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   full pipeline flush, clears all tracking
//   flush_unissued_instr_i    kills the instruction currently offered
//   issue_valid_i/rd_i/rd_fpr_i  scoreboard issue offer
//   issue_valid_o             gated valid toward renamer / issue stage
//   issue_ack_i               issue stage accepts the instruction
//   issue_ack_o               gated ack back to the scoreboard
//   commit_valid_i/rd_i/fpr_i per-port destination retirement
//   stall_o                   offered instruction is being held
//   stall_cnt_o               saturating count of cycles spent STALLED
//   err_o                     sticky: retire seen on a register with count 0
// -----------------------------------------------------------------------------
module rename_stall_ctrl #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned MAX_INFLIGHT    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         flush_unissued_instr_i,
  input  logic                         issue_valid_i,
  input  logic [4:0]                   issue_rd_i,
  input  logic                         issue_rd_fpr_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ack_i,
  output logic                         issue_ack_o,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
  input  logic [5*NR_COMMIT_PORTS-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_fpr_i,
  output logic                         stall_o,
  output logic [31:0]                  stall_cnt_o,
  output logic                         err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned DEC_W = $clog2(NR_COMMIT_PORTS + 1);
  // Room for count + one allocation without overflow before saturating.
  localparam int unsigned SUM_W = CNT_W + DEC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    STALLED = 1'b1
  } state_e;

  logic [CNT_W-1:0] cnt_gpr_r [32];
  logic [CNT_W-1:0] cnt_fpr_r [32];
  logic [CNT_W-1:0] cnt_gpr_nxt_s [32];
  logic [CNT_W-1:0] cnt_fpr_nxt_s [32];
  logic [CNT_W-1:0] sel_cnt_s;
  logic             rd_is_x0_s;
  logic             full_s;
  logic             err_hit_s;
  state_e           state_r;
  logic [31:0]      stall_cnt_r;
  logic             err_r;

  // Number of commit ports retiring the given register in the given file.
  function automatic logic [DEC_W-1:0] retire_hits(
    input logic                         fpr,
    input logic [4:0]                   rd,
    input logic [NR_COMMIT_PORTS-1:0]   vld,
    input logic [5*NR_COMMIT_PORTS-1:0] rds,
    input logic [NR_COMMIT_PORTS-1:0]   fprs
  );
    logic [DEC_W-1:0] n;
    n = '0;
    for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
      if (vld[p] && (fprs[p] == fpr) && (rds[p*5 +: 5] == rd)) begin
        n = n + DEC_W'(1);
      end
    end
    return n;
  endfunction

  // Net update clamped to [0, MAX_INFLIGHT].
  function automatic logic [CNT_W-1:0] sat_update(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic [DEC_W-1:0] dec
  );
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] dn;
    logic [CNT_W-1:0] res;
    up = SUM_W'(cnt) + SUM_W'(inc);
    dn = SUM_W'(dec);
    if (up <= dn) begin
      res = '0;
    end else if ((up - dn) >= SUM_W'(MAX_INFLIGHT)) begin
      res = CNT_MAX;
    end else begin
      res = CNT_W'(up - dn);
    end
    return res;
  endfunction

  // Stall decision uses only registered counts; same-cycle commits do not help.
  always_comb begin
    if (issue_rd_fpr_i) begin
      sel_cnt_s = cnt_fpr_r[issue_rd_i];
    end else begin
      sel_cnt_s = cnt_gpr_r[issue_rd_i];
    end
    rd_is_x0_s = !issue_rd_fpr_i && (issue_rd_i == 5'd0);
    full_s     = (sel_cnt_s == CNT_MAX) && !rd_is_x0_s;
  end

  assign issue_valid_o = issue_valid_i & ~full_s & ~flush_unissued_instr_i;
  assign issue_ack_o   = issue_ack_i & issue_valid_o;
  assign stall_o       = issue_valid_i & full_s & ~flush_unissued_instr_i;
  assign stall_cnt_o   = stall_cnt_r;
  assign err_o         = err_r;

  // Next value of every counter: allocation minus all retiring ports, saturated.
  always_comb begin
    err_hit_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [DEC_W-1:0] dec_g;
      logic [DEC_W-1:0] dec_f;
      logic             inc_g;
      logic             inc_f;
      dec_g = retire_hits(1'b0, 5'(i), commit_valid_i, commit_rd_i, commit_fpr_i);
      dec_f = retire_hits(1'b1, 5'(i), commit_valid_i, commit_rd_i, commit_fpr_i);
      inc_g = issue_ack_o && !issue_rd_fpr_i && (issue_rd_i == 5'(i));
      inc_f = issue_ack_o &&  issue_rd_fpr_i && (issue_rd_i == 5'(i));
      // x0 is never renamed, so its count is pinned and its retires are ignored.
      if (i == 0) begin
        cnt_gpr_nxt_s[i] = '0;
      end else begin
        cnt_gpr_nxt_s[i] = sat_update(cnt_gpr_r[i], inc_g, dec_g);
        if ((dec_g != '0) && (cnt_gpr_r[i] == '0)) begin
          err_hit_s = 1'b1;
        end else begin
          err_hit_s = err_hit_s;
        end
      end
      cnt_fpr_nxt_s[i] = sat_update(cnt_fpr_r[i], inc_f, dec_f);
      if ((dec_f != '0) && (cnt_fpr_r[i] == '0)) begin
        err_hit_s = 1'b1;
      end else begin
        err_hit_s = err_hit_s;
      end
    end
  end

  // In-flight counter tables; a flush discards the cycle's allocates and retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        cnt_gpr_r[i] <= '0;
        cnt_fpr_r[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < 32; i++) begin
        cnt_gpr_r[i] <= '0;
        cnt_fpr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_gpr_r[i] <= cnt_gpr_nxt_s[i];
        cnt_fpr_r[i] <= cnt_fpr_nxt_s[i];
      end
    end
  end

  // RUN/STALLED tracker with its stall-cycle statistic and the sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RUN;
      stall_cnt_r <= 32'd0;
      err_r       <= 1'b0;
    end else if (flush_i) begin
      state_r     <= RUN;
      stall_cnt_r <= stall_cnt_r;
      err_r       <= err_r;
    end else begin
      case (state_r)
        RUN:     state_r <= stall_o ? STALLED : RUN;
        STALLED: state_r <= stall_o ? STALLED : RUN;
        default: state_r <= RUN;
      endcase
      if ((state_r == STALLED) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      err_r <= err_r | err_hit_s;
    end
  end

endmodule
